// File: rtl/switch_pkg.sv
// Shared definitions for the FIFO switch control path: state encoding
// and default widths.
package switch_pkg;

   localparam int NUM_FIFOS_DEF = 8;
   localparam int TH_WIDTH_DEF  = 3;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

endpackage

// File: rtl/switch_ctrl_fsm_idle_timer.sv
// Counts consecutive all-empty cycles while the switch is active and
// flags the cycle on which the switch may fall back to idle.
module idle_timer #(
   parameter int IDLE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic all_empty,
   output logic expire
);

   localparam int             CW   = $clog2(IDLE_CYCLES) + 1;
   localparam logic [CW-1:0]  LAST = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0]  MAX  = '1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire = en && all_empty && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!en || !all_empty || expire) begin
         cnt_d = '0;
      end else if (cnt_q != MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/switch_ctrl_fsm.sv
// Top-level control FSM of the 4x4 FIFO switch: threshold configuration,
// idle/active sequencing and sticky overflow error capture.
module switch_ctrl_fsm
   import switch_pkg::*;
#(
   parameter int NUM_FIFOS   = NUM_FIFOS_DEF,
   parameter int TH_WIDTH    = TH_WIDTH_DEF,
   parameter int IDLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [TH_WIDTH-1:0]  alto_in,
   input  logic [TH_WIDTH-1:0]  bajo_in,
   input  logic [NUM_FIFOS-1:0] empty_fifos,
   input  logic [NUM_FIFOS-1:0] full_fifos,
   input  logic [NUM_FIFOS-1:0] push_fifos,
   output logic [TH_WIDTH-1:0]  alto,
   output logic [TH_WIDTH-1:0]  bajo,
   output logic [2:0]           state,
   output logic                 idle,
   output logic                 active,
   output logic                 error_out,
   output logic [NUM_FIFOS-1:0] error_mask,
   output logic                 cfg_reject
);

   state_e                state_q, state_d;
   logic [TH_WIDTH-1:0]   alto_q, alto_d;
   logic [TH_WIDTH-1:0]   bajo_q, bajo_d;
   logic [NUM_FIFOS-1:0]  error_mask_q, error_mask_d;
   logic                  cfg_reject_q, cfg_reject_d;
   logic                  cfg_ok_q, cfg_ok_d;

   logic [NUM_FIFOS-1:0]  ovf;
   logic                  any_ovf;
   logic                  all_empty;
   logic                  cfg_valid;
   logic                  idle_expire;

   assign ovf       = push_fifos & full_fifos;
   assign any_ovf   = |ovf;
   assign all_empty = &empty_fifos;
   // Unsigned compare; alto_in==0 can never exceed bajo_in, so it is rejected.
   assign cfg_valid = (bajo_in < alto_in);

   idle_timer #(
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_idle_timer (
      .clk       (clk),
      .reset     (reset),
      .en        (state_q == ST_ACTIVE),
      .all_empty (all_empty),
      .expire    (idle_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_RESET;
         alto_q       <= '0;
         bajo_q       <= '0;
         error_mask_q <= '0;
         cfg_reject_q <= 1'b0;
         cfg_ok_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         alto_q       <= alto_d;
         bajo_q       <= bajo_d;
         error_mask_q <= error_mask_d;
         cfg_reject_q <= cfg_reject_d;
         cfg_ok_q     <= cfg_ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init && cfg_ok_q) state_d = ST_IDLE;
         ST_IDLE: begin
            if (any_ovf)         state_d = ST_ERROR;
            else if (init)       state_d = ST_INIT;
            else if (!all_empty) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_ovf)          state_d = ST_ERROR;
            else if (idle_expire) state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_comb begin
      alto_d       = alto_q;
      bajo_d       = bajo_q;
      error_mask_d = error_mask_q;
      cfg_reject_d = 1'b0;
      cfg_ok_d     = cfg_ok_q;

      if (state_q == ST_INIT && init) begin
         if (cfg_valid) begin
            alto_d   = alto_in;
            bajo_d   = bajo_in;
            cfg_ok_d = 1'b1;
         end else begin
            cfg_reject_d = 1'b1;
         end
      end

      // A fresh pass through INIT must be reconfigured before leaving it.
      if (state_d == ST_INIT && state_q != ST_INIT) begin
         cfg_ok_d = 1'b0;
      end

      if (state_q == ST_IDLE || state_q == ST_ACTIVE || state_q == ST_ERROR) begin
         error_mask_d = error_mask_q | ovf;
      end
   end

   assign alto       = alto_q;
   assign bajo       = bajo_q;
   assign state      = state_q;
   assign idle       = (state_q == ST_IDLE);
   assign active     = (state_q == ST_ACTIVE);
   assign error_out  = (state_q == ST_ERROR);
   assign error_mask = error_mask_q;
   assign cfg_reject = cfg_reject_q;

endmodule
